// File: rtl/life_engine_core.sv
// life_engine_core
// Conway-style cellular-automaton engine. Holds the current board and a
// next-generation shadow board, and executes STEP / RANDOMIZE / CLEAR /
// TOGGLE commands accepted over a valid/ready handshake. Birth and survive
// rules, edge handling and the LFSR seed are parameters. Generation,
// population, stable and extinct statistics are kept alongside the board.
// The display side scans the current board through a registered read port.

module life_engine_core #(
   parameter int unsigned LOG_W        = 6,
   parameter int unsigned LOG_H        = 5,
   parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
   parameter int unsigned WRAP         = 1,
   parameter logic [15:0] LFSR_SEED    = 16'h0001
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [LOG_W+LOG_H-1:0] cmd_addr,
   input  logic [LOG_W+LOG_H-1:0] rd_addr,
   output logic                   rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            generation,
   output logic [LOG_W+LOG_H:0]   population,
   output logic                   stable,
   output logic                   extinct
);

   localparam int unsigned AW    = LOG_W + LOG_H;
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned BOARD = 1 << AW;

   localparam logic [1:0] OP_STEP      = 2'd0;
   localparam logic [1:0] OP_RANDOMIZE = 2'd1;
   localparam logic [1:0] OP_CLEAR     = 2'd2;
   localparam logic [1:0] OP_TOGGLE    = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      UPDATE = 3'd2,
      COPY   = 3'd3,
      TOGGLE = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [BOARD-1:0]  curBoard_q;
   logic [BOARD-1:0]  nextBoard_q;

   logic [15:0]       lfsr_q;
   logic [15:0]       lfsr_d;

   logic [AW-1:0]     cellIdx_q;
   logic [3:0]        phase_q;
   logic [3:0]        count_q;
   logic [PW-1:0]     popAcc_q;
   logic              changed_q;
   logic              isRandom_q;
   logic [AW-1:0]     togAddr_q;

   logic              done_q;
   logic [15:0]       generation_q;
   logic [PW-1:0]     population_q;
   logic              stable_q;
   logic              rdData_q;

   logic              accept;
   logic              lastCell;
   logic              finishing;
   logic [LOG_W-1:0]  cellX;
   logic [LOG_H-1:0]  cellY;
   logic [LOG_W-1:0]  nbrX;
   logic [LOG_H-1:0]  nbrY;
   logic              dxNeg;
   logic              dxPos;
   logic              dyNeg;
   logic              dyPos;
   logic              offBoard;
   logic              nbrLive;
   logic              selfLive;
   logic              nextLive;
   logic              newCell;
   logic              initBit;

   assign accept    = cmd_valid && (state_q == IDLE);
   assign lastCell  = &cellIdx_q;
   assign cellX     = cellIdx_q[LOG_W-1:0];
   assign cellY     = cellIdx_q[AW-1:LOG_W];
   assign selfLive  = curBoard_q[cellIdx_q];
   assign nextLive  = nextBoard_q[cellIdx_q];
   assign initBit   = isRandom_q & lfsr_q[0];
   assign newCell   = selfLive ? SURVIVE_MASK[count_q] : BIRTH_MASK[count_q];

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign generation = generation_q;
   assign population = population_q;
   assign stable     = stable_q;
   assign extinct    = (population_q == '0);
   assign rd_data    = rdData_q;

   // Free-running Fibonacci LFSR: shift left, taps 15/13/12/10 feed bit 0.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Map the UPDATE phase (0..7) onto one of the eight neighbour offsets.
   always_comb begin
      dxNeg = 1'b0;
      dxPos = 1'b0;
      dyNeg = 1'b0;
      dyPos = 1'b0;
      case (phase_q)
         4'd0: begin dxNeg = 1'b1; dyNeg = 1'b1; end
         4'd1: dyNeg = 1'b1;
         4'd2: begin dxPos = 1'b1; dyNeg = 1'b1; end
         4'd3: dxNeg = 1'b1;
         4'd4: dxPos = 1'b1;
         4'd5: begin dxNeg = 1'b1; dyPos = 1'b1; end
         4'd6: dyPos = 1'b1;
         4'd7: begin dxPos = 1'b1; dyPos = 1'b1; end
         default: ;
      endcase
   end

   // Neighbour coordinates wrap naturally in LOG_W/LOG_H bits; offBoard
   // flags the ones that crossed an edge so a bounded board can mask them.
   always_comb begin
      nbrX = cellX;
      nbrY = cellY;
      if (dxNeg) nbrX = cellX - LOG_W'(1);
      if (dxPos) nbrX = cellX + LOG_W'(1);
      if (dyNeg) nbrY = cellY - LOG_H'(1);
      if (dyPos) nbrY = cellY + LOG_H'(1);
      offBoard = (dxNeg && (cellX == '0)) || (dxPos && (cellX == '1)) ||
                 (dyNeg && (cellY == '0)) || (dyPos && (cellY == '1));
      nbrLive  = curBoard_q[{nbrY, nbrX}] && ((WRAP != 0) || !offBoard);
   end

   // Next-state logic for the command sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_STEP:   state_d = UPDATE;
                  OP_TOGGLE: state_d = TOGGLE;
                  default:   state_d = INIT;
               endcase
            end
         end
         INIT:    if (lastCell) state_d = IDLE;
         UPDATE:  if (lastCell && (phase_q == 4'd8)) state_d = COPY;
         COPY:    if (lastCell) state_d = IDLE;
         TOGGLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign finishing = (state_q != IDLE) && (state_d == IDLE);

   // State register and LFSR; reset aborts any command in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
      end
   end

   // Sequencing counters, statistics and the registered display read.
   always_ff @(posedge clk) begin
      if (reset) begin
         cellIdx_q    <= '0;
         phase_q      <= '0;
         count_q      <= '0;
         popAcc_q     <= '0;
         changed_q    <= 1'b0;
         isRandom_q   <= 1'b0;
         togAddr_q    <= '0;
         done_q       <= 1'b0;
         generation_q <= '0;
         population_q <= '0;
         stable_q     <= 1'b0;
         rdData_q     <= 1'b0;
      end else begin
         done_q   <= finishing;
         rdData_q <= curBoard_q[rd_addr];
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cellIdx_q  <= '0;
                  phase_q    <= '0;
                  count_q    <= '0;
                  popAcc_q   <= '0;
                  changed_q  <= 1'b0;
                  isRandom_q <= (cmd_op == OP_RANDOMIZE);
                  togAddr_q  <= cmd_addr;
                  if ((cmd_op == OP_RANDOMIZE) || (cmd_op == OP_CLEAR)) begin
                     generation_q <= '0;
                  end
               end
            end
            INIT: begin
               cellIdx_q <= cellIdx_q + AW'(1);
               popAcc_q  <= popAcc_q + PW'(initBit);
               if (lastCell) begin
                  population_q <= popAcc_q + PW'(initBit);
                  stable_q     <= 1'b0;
               end
            end
            UPDATE: begin
               if (phase_q == 4'd8) begin
                  phase_q   <= '0;
                  count_q   <= '0;
                  cellIdx_q <= cellIdx_q + AW'(1);
               end else begin
                  phase_q <= phase_q + 4'd1;
                  count_q <= count_q + {3'b000, nbrLive};
               end
            end
            COPY: begin
               cellIdx_q <= cellIdx_q + AW'(1);
               popAcc_q  <= popAcc_q + PW'(nextLive);
               if (selfLive != nextLive) changed_q <= 1'b1;
               if (lastCell) begin
                  population_q <= popAcc_q + PW'(nextLive);
                  stable_q     <= !(changed_q || (selfLive != nextLive));
                  generation_q <= generation_q + 16'd1;
               end
            end
            TOGGLE: begin
               if (curBoard_q[togAddr_q]) population_q <= population_q - PW'(1);
               else                       population_q <= population_q + PW'(1);
            end
            default: ;
         endcase
      end
   end

   // Board storage; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         case (state_q)
            INIT:    curBoard_q[cellIdx_q] <= initBit;
            COPY:    curBoard_q[cellIdx_q] <= nextLive;
            TOGGLE:  curBoard_q[togAddr_q] <= ~curBoard_q[togAddr_q];
            default: ;
         endcase
         if ((state_q == UPDATE) && (phase_q == 4'd8)) begin
            nextBoard_q[cellIdx_q] <= newCell;
         end
      end
   end

endmodule

// File: tb/tb_life_engine_core.sv
// tb_life_engine_core
// Directed bench for life_engine_core on a 16x8 board. Two engines share
// the same command stream, one toroidal and one with dead borders, so edge
// behaviour can be compared side by side.

module tb_life_engine_core;

   localparam int LOG_W    = 4;
   localparam int LOG_H    = 3;
   localparam int W        = 16;
   localparam int AW       = LOG_W + LOG_H;
   localparam int PW       = AW + 1;
   localparam int BOARD    = 1 << AW;
   localparam int STEP_LAT = 10 * BOARD + 1;
   localparam int INIT_LAT = BOARD + 1;
   localparam int TOG_LAT  = 2;

   localparam logic [1:0] OP_STEP      = 2'd0;
   localparam logic [1:0] OP_RANDOMIZE = 2'd1;
   localparam logic [1:0] OP_CLEAR     = 2'd2;
   localparam logic [1:0] OP_TOGGLE    = 2'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmdValid = 1'b0;
   logic [1:0]    cmdOp = 2'd0;
   logic [AW-1:0] cmdAddr = '0;
   logic [AW-1:0] rdAddr = '0;

   logic          cmdReadyW, rdDataW, busyW, doneW, stableW, extinctW;
   logic [15:0]   generationW;
   logic [PW-1:0] populationW;
   logic          cmdReadyN, rdDataN, busyN, doneN, stableN, extinctN;
   logic [15:0]   generationN;
   logic [PW-1:0] populationN;

   logic [15:0]      modelLfsr;
   logic [BOARD-1:0] expW;
   logic [BOARD-1:0] expN;
   int               checks = 0;
   int               errors = 0;
   int               holdCycles;
   int               busyCount;
   logic             sawDone;

   life_engine_core #(.LOG_W(LOG_W), .LOG_H(LOG_H), .WRAP(1)) dutWrap (
      .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(cmdReadyW),
      .cmd_op(cmdOp), .cmd_addr(cmdAddr), .rd_addr(rdAddr), .rd_data(rdDataW),
      .busy(busyW), .done(doneW), .generation(generationW),
      .population(populationW), .stable(stableW), .extinct(extinctW)
   );

   life_engine_core #(.LOG_W(LOG_W), .LOG_H(LOG_H), .WRAP(0)) dutNoWrap (
      .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(cmdReadyN),
      .cmd_op(cmdOp), .cmd_addr(cmdAddr), .rd_addr(rdAddr), .rd_data(rdDataN),
      .busy(busyN), .done(doneN), .generation(generationN),
      .population(populationN), .stable(stableN), .extinct(extinctN)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Reference LFSR: seed on reset, shift left with taps 15/13/12/10 otherwise.
   always @(posedge clk) begin
      if (reset) modelLfsr <= 16'h0001;
      else       modelLfsr <= {modelLfsr[14:0], modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
   end

   // Hard stop in case a wait loop is miswritten.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [AW-1:0] cellAddr(input int x, input int y);
      return AW'(y * W + x);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr);
      @(negedge clk);
      cmdValid = 1'b1;
      cmdOp    = op;
      cmdAddr  = addr;
   endtask

   // Issue one command and wait (bounded) for its done pulse.
   task automatic runCmd(input string tag, input logic [1:0] op, input logic [AW-1:0] addr, input int expLat);
      int n;
      n = 0;
      applyStimulus(op, addr);
      do begin
         @(negedge clk);
         n++;
         if (n == 1) cmdValid = 1'b0;
      end while (!doneW && (n < expLat + 50));
      checkOutput({tag, "_latency"}, n, expLat);
      checkOutput({tag, "_doneNoWrap"}, doneN, 1);
   endtask

   task automatic checkStats(input string tag, input bit noWrap, input logic [15:0] expGen,
                             input int expPop, input logic expStable);
      if (noWrap) begin
         checkOutput({tag, "_genN"}, generationN, expGen);
         checkOutput({tag, "_popN"}, populationN, expPop);
         checkOutput({tag, "_stableN"}, stableN, expStable);
         checkOutput({tag, "_extinctN"}, extinctN, (expPop == 0));
      end else begin
         checkOutput({tag, "_genW"}, generationW, expGen);
         checkOutput({tag, "_popW"}, populationW, expPop);
         checkOutput({tag, "_stableW"}, stableW, expStable);
         checkOutput({tag, "_extinctW"}, extinctW, (expPop == 0));
      end
   endtask

   // Scan every cell through the read port and count mismatches per engine.
   task automatic scanBoard(input string tag, input logic [BOARD-1:0] eW, input logic [BOARD-1:0] eN);
      int missW;
      int missN;
      missW = 0;
      missN = 0;
      @(negedge clk);
      rdAddr = '0;
      for (int i = 0; i < BOARD; i++) begin
         @(negedge clk);
         if (rdDataW !== eW[i]) missW++;
         if (rdDataN !== eN[i]) missN++;
         rdAddr = AW'(i + 1);
      end
      checkOutput({tag, "_boardW"}, missW, 0);
      checkOutput({tag, "_boardN"}, missN, 0);
   endtask

   task automatic toggleCell(input string tag, input int x, input int y);
      runCmd(tag, OP_TOGGLE, cellAddr(x, y), TOG_LAT);
   endtask

   // RANDOMIZE: expected cell i is the reference LFSR bit0 in INIT cycle i.
   task automatic randomRun(input string tag);
      logic [BOARD-1:0] expR;
      expR = '0;
      applyStimulus(OP_RANDOMIZE, '0);
      for (int i = 0; i < BOARD; i++) begin
         @(negedge clk);
         if (i == 0) cmdValid = 1'b0;
         expR[i] = modelLfsr[0];
      end
      @(negedge clk);
      checkOutput({tag, "_doneW"}, doneW, 1);
      checkOutput({tag, "_doneN"}, doneN, 1);
      checkStats(tag, 1'b0, 16'd0, $countones(expR), 1'b0);
      checkStats(tag, 1'b1, 16'd0, $countones(expR), 1'b0);
      scanBoard(tag, expR, expR);
   endtask

   task automatic clearBoard(input string tag);
      runCmd(tag, OP_CLEAR, '0, INIT_LAT);
      checkStats(tag, 1'b0, 16'd0, 0, 1'b0);
      checkStats(tag, 1'b1, 16'd0, 0, 1'b0);
   endtask

   initial begin
      // Reset values, observed while reset is held.
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("resetRdDataW", rdDataW, 0);
      checkOutput("resetRdDataN", rdDataN, 0);
      checkOutput("resetDoneW", doneW, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("resetReadyW", cmdReadyW, 1);
      checkOutput("resetBusyW", busyW, 0);
      checkOutput("resetDoneAfterW", doneW, 0);
      checkStats("reset", 1'b0, 16'd0, 0, 1'b0);
      checkStats("reset", 1'b1, 16'd0, 0, 1'b0);

      // CLEAR: every cell reads back zero.
      clearBoard("clear0");
      scanBoard("clear0", '0, '0);

      // Horizontal blinker, then two steps.
      toggleCell("blinkT0", 5, 3);
      checkOutput("blinkPop1W", populationW, 1);
      toggleCell("blinkT1", 6, 3);
      checkOutput("blinkPop2W", populationW, 2);
      toggleCell("blinkT2", 7, 3);
      checkStats("blinkSet", 1'b0, 16'd0, 3, 1'b0);
      runCmd("blinkStep1", OP_STEP, '0, STEP_LAT);
      checkStats("blinkStep1", 1'b0, 16'd1, 3, 1'b0);
      checkStats("blinkStep1", 1'b1, 16'd1, 3, 1'b0);
      expW = '0;
      expW[cellAddr(6, 2)] = 1'b1;
      expW[cellAddr(6, 3)] = 1'b1;
      expW[cellAddr(6, 4)] = 1'b1;
      scanBoard("blinkStep1", expW, expW);
      runCmd("blinkStep2", OP_STEP, '0, STEP_LAT);
      checkStats("blinkStep2", 1'b0, 16'd2, 3, 1'b0);
      checkStats("blinkStep2", 1'b1, 16'd2, 3, 1'b0);
      expW = '0;
      expW[cellAddr(5, 3)] = 1'b1;
      expW[cellAddr(6, 3)] = 1'b1;
      expW[cellAddr(7, 3)] = 1'b1;
      scanBoard("blinkStep2", expW, expW);

      // 2x2 block is a still life; toggles leave generation and stable alone.
      clearBoard("clear1");
      toggleCell("blockT0", 2, 2);
      toggleCell("blockT1", 3, 2);
      toggleCell("blockT2", 2, 3);
      toggleCell("blockT3", 3, 3);
      runCmd("blockStep", OP_STEP, '0, STEP_LAT);
      checkStats("blockStep", 1'b0, 16'd1, 4, 1'b1);
      checkStats("blockStep", 1'b1, 16'd1, 4, 1'b1);
      expW = '0;
      expW[cellAddr(2, 2)] = 1'b1;
      expW[cellAddr(3, 2)] = 1'b1;
      expW[cellAddr(2, 3)] = 1'b1;
      expW[cellAddr(3, 3)] = 1'b1;
      scanBoard("blockStep", expW, expW);
      toggleCell("blockTon", 12, 6);
      checkStats("blockTon", 1'b0, 16'd1, 5, 1'b1);
      toggleCell("blockToff", 12, 6);
      checkStats("blockToff", 1'b0, 16'd1, 4, 1'b1);

      // A lone cell dies.
      clearBoard("clear2");
      toggleCell("loneT", 9, 5);
      runCmd("loneStep", OP_STEP, '0, STEP_LAT);
      checkStats("loneStep", 1'b0, 16'd1, 0, 1'b0);
      checkStats("loneStep", 1'b1, 16'd1, 0, 1'b0);

      // Row across the x=0/x=15 seam at y=0.
      clearBoard("clear3");
      toggleCell("cornerT0", 15, 0);
      toggleCell("cornerT1", 0, 0);
      toggleCell("cornerT2", 1, 0);
      runCmd("cornerStep", OP_STEP, '0, STEP_LAT);
      checkStats("cornerStep", 1'b0, 16'd1, 3, 1'b0);
      checkStats("cornerStep", 1'b1, 16'd1, 0, 1'b0);
      expW = '0;
      expW[cellAddr(0, 7)] = 1'b1;
      expW[cellAddr(0, 0)] = 1'b1;
      expW[cellAddr(0, 1)] = 1'b1;
      expN = '0;
      scanBoard("cornerStep", expW, expN);

      // cmd_valid held high through a STEP: nothing else starts until done.
      @(negedge clk);
      cmdValid   = 1'b1;
      cmdOp      = OP_STEP;
      cmdAddr    = '0;
      holdCycles = 0;
      busyCount  = 0;
      do begin
         @(negedge clk);
         holdCycles++;
         if (busyW && !cmdReadyW && !doneW) busyCount++;
      end while (!doneW && (holdCycles < STEP_LAT + 50));
      checkOutput("holdLatency", holdCycles, STEP_LAT);
      checkOutput("holdBusyCycles", busyCount, STEP_LAT - 1);
      checkOutput("holdReadyAtDone", cmdReadyW, 1);
      checkStats("holdStep", 1'b0, 16'd2, 3, 1'b0);
      checkStats("holdStep", 1'b1, 16'd2, 0, 1'b1);
      @(negedge clk);
      cmdValid = 1'b0;
      checkOutput("backToBackBusyW", busyW, 1);
      checkOutput("backToBackDoneW", doneW, 0);

      // 8-cycle reset in the middle of UPDATE.
      repeat (20) @(negedge clk);
      sawDone = 1'b0;
      reset   = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (doneW || doneN) sawDone = 1'b1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (doneW || doneN) sawDone = 1'b1;
      end
      checkOutput("abortNoDone", sawDone, 0);
      checkOutput("abortBusyW", busyW, 0);
      checkOutput("abortReadyN", cmdReadyN, 1);
      checkStats("abort", 1'b0, 16'd0, 0, 1'b0);
      checkStats("abort", 1'b1, 16'd0, 0, 1'b0);

      // RANDOMIZE twice from identical reset timing against the LFSR model.
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      randomRun("random1");
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      randomRun("random2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
